// File: rtl/fetch_stage_core.sv
// Per-core MIPS32 instruction fetch stage: PC register, IF/ID pipeline register,
// branch/jump redirect, decode stall and halt once the PC runs off the end of instruction memory.
module fetch_stage_core #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        halted,
    output logic [31:0] fetch_count
);

    localparam logic [0:0]  ST_RUN    = 1'b0;
    localparam logic [0:0]  ST_HALT   = 1'b1;
    localparam logic [31:0] DEPTH_W   = 32'(IMEM_DEPTH);
    localparam logic [31:0] PC_RESET  = {RESET_PC[31:2], 2'b00};
    localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

    logic [0:0]  state_q, state_n;
    logic [31:0] pc_q, pc_n;
    logic [31:0] instr_q, instr_n;
    logic [31:0] pc4_q, pc4_n;
    logic        valid_q, valid_n;
    logic [31:0] fetch_count_q, fetch_count_n;

    logic [31:0] pc_plus4;
    logic [31:0] word_index;
    logic        at_end;
    logic [31:0] count_inc;

    assign pc_plus4   = pc_q + 32'd4;
    assign word_index = {2'b00, pc_q[31:2]};
    assign at_end     = (word_index >= DEPTH_W);
    assign count_inc  = (fetch_count_q == COUNT_MAX) ? COUNT_MAX : fetch_count_q + 32'd1;

    // Redirect overrides everything, including a halted core and a stalled decode.
    always_comb begin
        state_n       = state_q;
        pc_n          = pc_q;
        instr_n       = instr_q;
        pc4_n         = pc4_q;
        valid_n       = valid_q;
        fetch_count_n = fetch_count_q;

        if (redirect) begin
            state_n = ST_RUN;
            pc_n    = {redirect_pc[31:2], 2'b00};
            instr_n = 32'd0;
            valid_n = 1'b0;
        end else if (state_q == ST_HALT) begin
            valid_n = 1'b0;
        end else if (stall) begin
            valid_n = valid_q;
        end else if (at_end) begin
            state_n = ST_HALT;
            instr_n = 32'd0;
            valid_n = 1'b0;
        end else begin
            pc_n          = pc_plus4;
            instr_n       = imem_instr;
            pc4_n         = pc_plus4;
            valid_n       = 1'b1;
            fetch_count_n = count_inc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            pc_q          <= PC_RESET;
            instr_q       <= 32'd0;
            pc4_q         <= 32'd0;
            valid_q       <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_n;
            pc_q          <= pc_n;
            instr_q       <= instr_n;
            pc4_q         <= pc4_n;
            valid_q       <= valid_n;
            fetch_count_q <= fetch_count_n;
        end
    end

    assign imem_addr   = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;
    assign halted      = (state_q == ST_HALT);
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage_core.sv
// Directed self-checking bench for fetch_stage_core: fetch, stall, redirect, end-of-memory
// halt, asynchronous reset, and PC wrap / fetch_count saturation on a huge-memory instance.
module tb_fetch_stage_core;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall, redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr, imem_instr;
    logic [31:0] if_id_instr, if_id_pc4, fetch_count;
    logic        if_id_valid, halted;

    logic        reset2_n;
    logic        stall2, redirect2;
    logic [31:0] redirect_pc2;
    logic [31:0] imem_addr2;
    logic [31:0] imem_instr2 = 32'hDEAD_BEEF;
    logic [31:0] if_id_instr2, if_id_pc42, fetch_count2;
    logic        if_id_valid2, halted2;

    logic [31:0] mem [64];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    assign imem_instr = mem[imem_addr[7:2]];

    fetch_stage_core #(.RESET_PC(32'h0), .IMEM_DEPTH(64)) dut (
        .clk(clk), .reset(reset_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
        .halted(halted), .fetch_count(fetch_count)
    );

    fetch_stage_core #(.RESET_PC(32'h0), .IMEM_DEPTH(1 << 30)) dut_big (
        .clk(clk), .reset(reset2_n), .stall(stall2), .redirect(redirect2),
        .redirect_pc(redirect_pc2), .imem_addr(imem_addr2), .imem_instr(imem_instr2),
        .if_id_instr(if_id_instr2), .if_id_pc4(if_id_pc42), .if_id_valid(if_id_valid2),
        .halted(halted2), .fetch_count(fetch_count2)
    );

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic s, input logic r, input logic [31:0] rpc);
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_if_id(input string tag, input logic [31:0] instr, input logic [31:0] pc4,
                               input logic valid, input logic [31:0] pc, input logic [31:0] count);
        check_output({tag, ".instr"}, if_id_instr, instr);
        check_output({tag, ".pc4"},   if_id_pc4,   pc4);
        check_output({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, valid});
        check_output({tag, ".pc"},    imem_addr,   pc);
        check_output({tag, ".count"}, fetch_count, count);
    endtask

    initial begin
        mem[0] = 32'h2008_0005;
        mem[1] = 32'h2009_000A;
        mem[2] = 32'h0109_5020;
        for (int i = 3; i < 64; i++) mem[i] = 32'h1000_0000 | 32'(i);

        reset_n  = 1'b0;
        reset2_n = 1'b0;
        apply_stimulus(1'b0, 1'b0, 32'h0);
        stall2 = 1'b1; redirect2 = 1'b0; redirect_pc2 = 32'h0;
        #2;
        check_if_id("reset", 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        check_output("reset.halted", {31'd0, halted}, 32'd0);

        tick();
        reset_n  = 1'b1;
        reset2_n = 1'b1;

        // Sequential fetch of words 0..2 with a two-cycle stall after the second.
        tick(); check_if_id("fetch0", 32'h2008_0005, 32'h4, 1'b1, 32'h4, 32'd1);
        tick(); check_if_id("fetch1", 32'h2009_000A, 32'h8, 1'b1, 32'h8, 32'd2);
        apply_stimulus(1'b1, 1'b0, 32'h0);
        tick(); check_if_id("stall1", 32'h2009_000A, 32'h8, 1'b1, 32'h8, 32'd2);
        tick(); check_if_id("stall2", 32'h2009_000A, 32'h8, 1'b1, 32'h8, 32'd2);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        tick(); check_if_id("fetch2", 32'h0109_5020, 32'hC, 1'b1, 32'hC, 32'd3);
        tick(); check_if_id("fetch3", 32'h1000_0003, 32'h10, 1'b1, 32'h10, 32'd4);

        // Redirect to an unaligned target: low bits dropped, one bubble.
        apply_stimulus(1'b0, 1'b1, 32'h23);
        tick(); check_if_id("redir.bubble", 32'h0, 32'h10, 1'b0, 32'h20, 32'd4);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        tick(); check_if_id("redir.target", 32'h1000_0008, 32'h24, 1'b1, 32'h24, 32'd5);

        apply_stimulus(1'b1, 1'b1, 32'h23);
        tick(); check_if_id("redir_stall.bubble", 32'h0, 32'h24, 1'b0, 32'h20, 32'd5);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        tick(); check_if_id("redir_stall.target", 32'h1000_0008, 32'h24, 1'b1, 32'h24, 32'd6);

        // Get to pc=0x18 with a valid instruction, then reset without a clock edge.
        apply_stimulus(1'b0, 1'b1, 32'h14);
        tick();
        apply_stimulus(1'b0, 1'b0, 32'h0);
        tick(); check_if_id("pre_reset", 32'h1000_0005, 32'h18, 1'b1, 32'h18, 32'd7);
        reset_n = 1'b0;
        #1;
        check_if_id("async_reset", 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        check_output("async_reset.halted", {31'd0, halted}, 32'd0);
        tick();
        reset_n = 1'b1;

        // Run the whole memory, then expect the halt.
        for (int i = 0; i < 64; i++) tick();
        check_if_id("last_word", 32'h1000_003F, 32'h100, 1'b1, 32'h100, 32'd64);
        check_output("last_word.halted", {31'd0, halted}, 32'd0);
        tick();
        check_if_id("halt", 32'h0, 32'h100, 1'b0, 32'h100, 32'd64);
        check_output("halt.halted", {31'd0, halted}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(i[0], 1'b0, 32'h0);
            tick();
        end
        check_if_id("halt_stall", 32'h0, 32'h100, 1'b0, 32'h100, 32'd64);
        check_output("halt_stall.halted", {31'd0, halted}, 32'd1);
        apply_stimulus(1'b0, 1'b1, 32'h0);
        tick(); check_if_id("restart.bubble", 32'h0, 32'h100, 1'b0, 32'h0, 32'd64);
        check_output("restart.halted", {31'd0, halted}, 32'd0);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        tick(); check_if_id("restart.fetch", 32'h2008_0005, 32'h4, 1'b1, 32'h4, 32'd65);

        // Huge-memory instance: PC wrap and saturating fetch_count.
        redirect2 = 1'b1; redirect_pc2 = 32'hFFFF_FFFC;
        tick();
        redirect2 = 1'b0;
        check_output("wrap.pc_before", imem_addr2, 32'hFFFF_FFFC);
        force dut_big.fetch_count_q = 32'hFFFF_FFFF;
        #1;
        release dut_big.fetch_count_q;
        stall2 = 1'b0;
        tick();
        check_output("wrap.pc", imem_addr2, 32'h0);
        check_output("wrap.pc4", if_id_pc42, 32'h0);
        check_output("wrap.instr", if_id_instr2, 32'hDEAD_BEEF);
        check_output("wrap.valid", {31'd0, if_id_valid2}, 32'd1);
        check_output("wrap.count", fetch_count2, 32'hFFFF_FFFF);
        check_output("wrap.halted", {31'd0, halted2}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage_core.md
# fetch_stage_core

Per-core instruction fetch stage of the dual-core MIPS32 processor. It holds the program counter and drives the word-indexed instruction memory's read address. It captures the returned instruction together with PC+4 into the IF/ID pipeline register. It handles stall, branch/jump redirect, and an end-of-program halt when the PC runs past the instruction memory.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0).
- IMEM_DEPTH, 64, instruction memory depth in 32-bit words; fetch limit.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- stall  in  1  hazard stall from decode; holds PC and IF/ID.
- redirect  in  1  taken branch/jump from a later stage.
- redirect_pc  in  32  redirect target byte address.
- imem_addr  out  32  byte address to instruction memory read_address (= PC register).
- imem_instr  in  32  instruction word from instruction memory (combinational, same cycle).
- if_id_instr  out  32  registered instruction.
- if_id_pc4  out  32  registered PC+4 of that instruction.
- if_id_valid  out  1  IF/ID contents are a real instruction.
- halted  out  1  fetch stopped at end of memory.
- fetch_count  out  32  number of instructions delivered to IF/ID.

## Operation
- State machine: RUN, HALT. Reset enters RUN.
- Reset values (asserted asynchronously while reset=0):
  - pc = RESET_PC.
  - if_id_instr = 0, if_id_pc4 = 0, if_id_valid = 0.
  - halted = 0, fetch_count = 0.
- Priority each edge: redirect > stall > end-of-memory check > normal fetch.
- Redirect (either state):
  - pc <= {redirect_pc[31:2], 2'b00}.
  - if_id_valid <= 0, if_id_instr <= 0 (bubble).
  - if_id_pc4 holds; fetch_count holds; state <= RUN.
- RUN, stall=1, no redirect: pc, IF/ID and fetch_count all hold.
- RUN, no stall, (pc>>2) >= IMEM_DEPTH:
  - state <= HALT, if_id_valid <= 0, if_id_instr <= 0.
  - pc holds.
- RUN, normal fetch:
  - if_id_instr <= imem_instr, if_id_pc4 <= pc+4, if_id_valid <= 1.
  - pc <= pc+4.
  - fetch_count <= fetch_count+1.
- HALT:
  - halted = 1 (decoded from state); pc and IF/ID held with if_id_valid = 0.
  - stall is ignored.
  - Only redirect or reset leaves HALT.
- Arithmetic:
  - pc+4 is modulo 2^32 (0xFFFF_FFFC wraps to 0).
  - fetch_count saturates at 32'hFFFF_FFFF.
- imem_addr = pc at all times, never gated.

## Timing
- Fetch latency: the instruction at pc is visible on if_id_instr after the next rising edge. Throughput is 1 instruction/cycle.
- Redirect penalty: exactly one bubble.
  - Edge N samples redirect.
  - Edge N+1 loads the target instruction into IF/ID with valid=1, unless stalled.
- Stall takes effect at the edge where it is sampled high. Fetch resumes the first edge it is sampled low.
- Redirect and stall both high: redirect wins; the bubble is inserted even though decode is stalled.
- halted rises at the edge that detects end-of-memory and falls at the edge that takes a redirect.
- Reset deassertion is synchronous in effect: the first fetch of RESET_PC is captured on the first rising edge with reset=1.

## Test plan
- Reset: hold reset=0 mid-run with pc=0x18 and valid=1.
  - Required: outputs go immediately (no clock) to pc=0, valid=0, fetch_count=0, halted=0.
- Sequential fetch: memory holds 0x20080005, 0x2009000A, 0x01095020 at words 0–2.
  - Required: over 3 edges, if_id_instr = those words, if_id_pc4 = 4, 8, 0xC, valid=1, fetch_count=3.
- Stall: stall=1 for 2 cycles while if_id_instr=0x2009000A.
  - Required: IF/ID, pc=8 and fetch_count unchanged; next edge loads 0x01095020.
- Redirect: redirect=1, redirect_pc=0x23 at pc=0x10.
  - Required: next edge pc=0x20, valid=0.
  - Following edge: if_id_instr=mem[8], if_id_pc4=0x24.
  - Repeat with stall=1 simultaneously: same result.
- End of memory: IMEM_DEPTH=64, run to pc=0x100.
  - Required: halted=1, valid=0, fetch_count=64, state stays HALT under stall toggling.
  - redirect_pc=0x0 then restarts fetch, halted=0.
- Wrap/saturation: force pc=0xFFFF_FFFC with IMEM_DEPTH=2^30 and fetch_count=0xFFFF_FFFF, fetch once.
  - Required: pc=0, if_id_pc4=0, fetch_count stays 0xFFFF_FFFF.
